// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
//
// Parametrised UART receiver. The asynchronous serial line is synchronised,
// start bits are qualified at mid-bit (short low pulses are rejected as
// glitches), data bits are sampled at the centre of each bit period (LSB
// first) and the finished word is handed to the consumer over a four-phase
// REQ/ACK handshake. Framing errors, an optional parity check and a sticky
// overrun flag are reported alongside the word.
//
// Optional feature macro:
//   UART_RX_PARITY_EN  - when defined, one parity bit is expected between the
//                        last data bit and the stop bit and is checked against
//                        PARITY_ODD. When undefined, frames are DATA_BITS+2 bits
//                        long and PAR_ERR is tied to 0.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit period (4..65535)
//   DATA_BITS     data bits per frame (5..8)
//   PARITY_ODD    0 = even parity, 1 = odd parity (parity build only)
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   clr        synchronous active-high reset
//   RCV        asynchronous serial input, idle high
//   RCV_ACK    consumer acknowledge
//   RCV_REQ    data-valid request, held until RCV_ACK is seen
//   RCV_DATA   received word, LSB is the first bit on the line
//   FRAME_ERR  stop bit was sampled low for the delivered word
//   PAR_ERR    parity mismatch for the delivered word
//   OVERRUN    sticky: a finished frame was dropped because the previous
//              word was still unacknowledged; clears when RCV_REQ falls
// -----------------------------------------------------------------------------
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 RCV,
    input  logic                 RCV_ACK,
    output logic                 RCV_REQ,
    output logic [DATA_BITS-1:0] RCV_DATA,
    output logic                 FRAME_ERR,
    output logic                 PAR_ERR,
    output logic                 OVERRUN
);

    // -------------------------------------------------------------------------
    // Parameter sanity: refuse to elaborate an illegal configuration rather
    // than silently building a receiver with truncated counters.
    // -------------------------------------------------------------------------
    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("uart_rx_param: CLKS_PER_BIT must be in 4..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_rx_param: DATA_BITS must be in 5..8");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_rx_param: PARITY_ODD must be 0 or 1");
    end

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    // The baud counter starts at 0 on entry to each state, so the sample is
    // taken on the cycle the counter shows "period - 1".
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    // Receiver states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd5;
    localparam logic       ODD_BIT   = (PARITY_ODD != 0);
`endif

    // -------------------------------------------------------------------------
    // Two-stage synchroniser. Both stages reset to the idle (high) level so a
    // reset never looks like a start edge.
    // -------------------------------------------------------------------------
    logic sync_q1;
    logic sync_q2;
    logic rx_s;

    // NOTE: clocked state is written with non-blocking (<=) assignments so that
    // every register samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= RCV;
            sync_q2 <= sync_q1;
        end
    end

    assign rx_s = sync_q2;

    // -------------------------------------------------------------------------
    // Receive FSM and shift path
    // -------------------------------------------------------------------------
    logic [2:0]           state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [IDX_W-1:0]     idx_q,    idx_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic                 deliver;   // stop bit sampled this cycle
    logic                 stop_bad;  // ... and it was low
`ifdef UART_RX_PARITY_EN
    logic                 par_q,    par_d;
`endif

    // NOTE: every signal written in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        shift_d  = shift_q;
        deliver  = 1'b0;
        stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                // Mid-start-bit check: a line that is already high again was
                // only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    // Shift in from the top so the first bit ends up in bit 0.
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    // XOR over data and parity must equal ODD_BIT.
                    par_d   = (^shift_q) ^ rx_s ^ ODD_BIT;
                    state_d = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    deliver  = 1'b1;
                    stop_bad = ~rx_s;
                    // A low stop bit means a break or a badly framed line:
                    // wait for idle before hunting for the next start bit.
                    state_d  = rx_s ? ST_IDLE : ST_BREAK;
                end
            end

            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Holding register and four-phase handshake.
    //
    // The holding register only accepts a word when the previous transfer has
    // fully completed (REQ low and ACK low). Otherwise the finished frame is
    // dropped and OVERRUN records the loss. Because the shift path above never
    // waits on this logic, reception carries on during a slow handshake.
    // -------------------------------------------------------------------------
    logic load;

    assign load = deliver && !RCV_REQ && !RCV_ACK;

    always_ff @(posedge clk) begin
        if (clr) begin
            RCV_REQ   <= 1'b0;
            RCV_DATA  <= '0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            if (RCV_REQ && RCV_ACK) begin
                RCV_REQ <= 1'b0;
                OVERRUN <= 1'b0;
            end

            if (load) begin
                RCV_DATA  <= shift_q;
                FRAME_ERR <= stop_bad;
                RCV_REQ   <= 1'b1;
            end else if (deliver) begin
                // Placed after the clear above so a drop on the very edge the
                // handshake completes is still recorded.
                OVERRUN <= 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            PAR_ERR <= 1'b0;
        end else if (load) begin
            PAR_ERR <= par_q;
        end
    end
`else
    assign PAR_ERR = 1'b0;
`endif

endmodule
